// File: rtl/bin_to_bcd6.sv
// ============================================================================
// Module   : bin_to_bcd6
// Purpose  : Sequential 20-bit binary to six-digit BCD converter (double dabble)
//            with saturation, leading-zero blank mask and overflow flag.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bin_to_bcd6 #(
  parameter int BIN_W   = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999999
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [BIN_W-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  ovf,
  output logic                  bcd_valid
);

  localparam int                  BCD_W     = 4 * DIGITS;
  localparam int                  ITER_W    = $clog2(BIN_W);
  localparam logic [BIN_W-1:0]    SAT_VAL   = BIN_W'(MAX_VAL);
  localparam logic [ITER_W-1:0]   LAST_ITER = ITER_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0]   BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [BIN_W-1:0]    bin_q;
  logic [BCD_W-1:0]    work_q;
  logic [BCD_W-1:0]    work_adj;
  logic [ITER_W-1:0]   iter_q;
  logic                ovf_pend_q;
  logic [DIGITS-1:0]   blank_nxt;
  logic                accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (iter_q == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Add-3 correction: every nibble >= 5 is bumped before the shift so that the
  // doubling carries correctly into the next decimal digit.
  // ---------------------------------------------------------------------------
  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign work_adj[4*d +: 4] = (work_q[4*d +: 4] >= 4'd5)
                                ? work_q[4*d +: 4] + 4'd3
                                : work_q[4*d +: 4];
    end
  endgenerate

  // A digit is blanked when it and every more significant digit are zero.
  assign blank_nxt[DIGITS-1] = (work_q[BCD_W-1 -: 4] == 4'd0);
  assign blank_nxt[0]        = 1'b0;

  generate
    for (genvar d = 1; d < DIGITS-1; d++) begin : g_blank
      assign blank_nxt[d] = blank_nxt[d+1] && (work_q[4*d +: 4] == 4'd0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_q      <= '0;
      work_q     <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_data > SAT_VAL) begin
              bin_q      <= SAT_VAL;
              ovf_pend_q <= 1'b1;
            end else begin
              bin_q      <= in_data;
              ovf_pend_q <= 1'b0;
            end
            work_q <= '0;
            iter_q <= '0;
          end
        end
        SHIFT: begin
          work_q <= {work_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
          iter_q <= iter_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Held result registers, updated only in DONE
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcd         <= '0;
      digit_blank <= BLANK_RST;
      ovf         <= 1'b0;
      bcd_valid   <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      if (state == DONE) begin
        bcd         <= work_q;
        digit_blank <= blank_nxt;
        ovf         <= ovf_pend_q;
      end
    end
  end

endmodule

`default_nettype wire
